// File: rtl/uart_pkg.sv
// Shared UART definitions: serializer state encoding, oversampling constants and data masking.
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned TICK_CW    = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    // Clears every bit at or above nbits so narrow frames carry no stray data.
    function automatic logic [7:0] mask_data(input logic [7:0] data, input int unsigned nbits);
        logic [7:0] masked;
        masked = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i < nbits) begin
                masked[i] = data[i];
            end
        end
        return masked;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO for the transmit path; head is visible combinationally on RdData.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       WrEn,
    input  logic [7:0] WrData,
    input  logic       RdEn,
    output logic [7:0] RdData,
    output logic       Full,
    output logic       Empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_wr;
    logic          w_rd;

    assign Full   = (r_count == FULL_CNT);
    assign Empty  = (r_count == '0);
    assign RdData = r_mem[r_rd_ptr];

    // A write is refused on a full cycle even if a pop frees a slot on the same edge.
    assign w_wr = WrEn & ~Full;
    assign w_rd = RdEn & ~Empty;

    always_ff @(posedge Clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= WrData;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO drained back-to-back onto Tx as 8N1 (or 8E1) frames,
// paced by the 16x oversampling Tick.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned NBITS     = 8,
    parameter bit          PARITY_EN = 1'b0
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       Tick,
    input  logic       WrEn,
    input  logic [7:0] WrData,
    output logic       Full,
    output logic       Empty,
    output logic       Overflow,
    output logic       Tx,
    output logic       TxBusy,
    output logic       TxDone
);

    localparam logic [TICK_CW-1:0] TICK_LAST = TICK_CW'(OVERSAMPLE - 1);
    localparam logic [2:0]         BIT_LAST  = 3'(NBITS - 1);

    tx_state_e          r_state, w_state_next;
    logic [TICK_CW-1:0] r_tick_cnt, w_tick_next;
    logic [2:0]         r_bit_cnt, w_bit_next;
    logic [7:0]         r_shift, w_shift_next;
    logic               r_parity, w_parity_next;
    logic               r_tx, w_tx_next;
    logic               r_busy, w_busy_next;
    logic               r_done, w_done_next;
    logic               r_overflow;

    logic       w_pop;
    logic       w_full;
    logic       w_empty;
    logic [7:0] w_rd_data;
    logic [7:0] w_head;
    logic       w_bit_end;

    uart_tx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .Clk    (Clk),
        .Rst_n  (Rst_n),
        .WrEn   (WrEn),
        .WrData (WrData),
        .RdEn   (w_pop),
        .RdData (w_rd_data),
        .Full   (w_full),
        .Empty  (w_empty)
    );

    assign w_head    = mask_data(w_rd_data, NBITS);
    assign w_bit_end = Tick && (r_tick_cnt == TICK_LAST);

    assign Full     = w_full;
    assign Empty    = w_empty;
    assign Overflow = r_overflow;
    assign Tx       = r_tx;
    assign TxBusy   = r_busy;
    assign TxDone   = r_done;

    always_comb begin
        w_state_next  = r_state;
        w_tick_next   = r_tick_cnt;
        w_bit_next    = r_bit_cnt;
        w_shift_next  = r_shift;
        w_parity_next = r_parity;
        w_tx_next     = r_tx;
        w_busy_next   = r_busy;
        w_done_next   = 1'b0;
        w_pop         = 1'b0;

        // The 4-bit counter wraps 15->0 by itself, marking each bit boundary.
        if ((r_state != IDLE) && Tick) begin
            w_tick_next = r_tick_cnt + 1'b1;
        end

        unique case (r_state)
            IDLE: begin
                if (Tick && !w_empty) begin
                    w_pop         = 1'b1;
                    w_shift_next  = w_head;
                    w_parity_next = ^w_head;
                    w_tick_next   = '0;
                    w_tx_next     = 1'b0;
                    w_busy_next   = 1'b1;
                    w_state_next  = START;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_bit_next   = '0;
                    w_tx_next    = r_shift[0];
                    w_state_next = DATA;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    if (r_bit_cnt == BIT_LAST) begin
                        if (PARITY_EN) begin
                            w_tx_next    = r_parity;
                            w_state_next = PARITY;
                        end else begin
                            w_tx_next    = 1'b1;
                            w_state_next = STOP;
                        end
                    end else begin
                        w_bit_next   = r_bit_cnt + 1'b1;
                        w_shift_next = r_shift >> 1;
                        w_tx_next    = r_shift[1];
                    end
                end
            end
            PARITY: begin
                if (w_bit_end) begin
                    w_tx_next    = 1'b1;
                    w_state_next = STOP;
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    w_done_next = 1'b1;
                    // Chain straight into the next start bit so queued frames have no gap.
                    if (!w_empty) begin
                        w_pop         = 1'b1;
                        w_shift_next  = w_head;
                        w_parity_next = ^w_head;
                        w_tick_next   = '0;
                        w_tx_next     = 1'b0;
                        w_state_next  = START;
                    end else begin
                        w_tx_next    = 1'b1;
                        w_busy_next  = 1'b0;
                        w_state_next = IDLE;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state    <= IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_tick_cnt <= w_tick_next;
            r_bit_cnt  <= w_bit_next;
            r_shift    <= w_shift_next;
            r_parity   <= w_parity_next;
            r_tx       <= w_tx_next;
            r_busy     <= w_busy_next;
            r_done     <= w_done_next;
            r_overflow <= WrEn & w_full;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed self-checking bench: one 8N1 instance and one even-parity instance share Clk/Tick/Rst_n.
module tb_uart_tx_buffered;

    logic       Clk = 1'b0;
    logic       Rst_n;
    logic       tick_en;
    logic       tick_auto = 1'b0;
    logic       tick_man;
    logic [1:0] tick_div = '0;
    logic       Tick;
    logic       WrEn_a, WrEn_p;
    logic [7:0] WrData;
    logic       full_a, empty_a, ovf_a, tx_a, busy_a, done_a;
    logic       full_p, empty_p, ovf_p, tx_p, busy_p, done_p;
    logic       sel;
    logic       mon_tx, mon_done;
    int         tick_cnt = 0;
    int         n_vec = 0;
    int         n_miscmp = 0;

    always #5 Clk = ~Clk;

    assign Tick     = tick_auto | tick_man;
    assign mon_tx   = sel ? tx_p : tx_a;
    assign mon_done = sel ? done_p : done_a;

    // One Tick every fourth clock when enabled.
    always @(negedge Clk) begin
        if (tick_en) begin
            tick_div  <= tick_div + 2'd1;
            tick_auto <= (tick_div == 2'd3);
        end else begin
            tick_div  <= '0;
            tick_auto <= 1'b0;
        end
    end

    always @(posedge Clk) begin
        if (Tick) tick_cnt <= tick_cnt + 1;
    end

    uart_tx_buffered #(.DEPTH(16), .NBITS(8), .PARITY_EN(1'b0)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Tick(Tick), .WrEn(WrEn_a), .WrData(WrData),
        .Full(full_a), .Empty(empty_a), .Overflow(ovf_a), .Tx(tx_a), .TxBusy(busy_a),
        .TxDone(done_a)
    );

    uart_tx_buffered #(.DEPTH(16), .NBITS(8), .PARITY_EN(1'b1)) dut_p (
        .Clk(Clk), .Rst_n(Rst_n), .Tick(Tick), .WrEn(WrEn_p), .WrData(WrData),
        .Full(full_p), .Empty(empty_p), .Overflow(ovf_p), .Tx(tx_p), .TxBusy(busy_p),
        .TxDone(done_p)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic wr(input logic s, input logic [7:0] d);
        @(negedge Clk);
        WrData = d;
        if (s) WrEn_p = 1'b1;
        else   WrEn_a = 1'b1;
        @(posedge Clk);
        #1;
        WrEn_a = 1'b0;
        WrEn_p = 1'b0;
    endtask

    function automatic logic [15:0] frame8(input logic [7:0] d);
        return {6'b0, 1'b1, d, 1'b0};
    endfunction

    // Waits for a start bit, samples each bit mid-period by tick count, stops at TxDone.
    task automatic rx_frame(input int nb, output logic [15:0] bits, output int t0,
                            output int len);
        int g;
        bits = '0;
        g = 0;
        while (mon_tx !== 1'b0 && g < 4000) begin
            step();
            g++;
        end
        if (mon_tx !== 1'b0) check_eq("rx_start", 32'(mon_tx), 0);
        t0 = tick_cnt;
        for (int b = 0; b < nb; b++) begin
            g = 0;
            while (tick_cnt < t0 + 16 * b + 8 && g < 200) begin
                step();
                g++;
            end
            bits[b] = mon_tx;
        end
        g = 0;
        while (mon_done !== 1'b1 && g < 2000) begin
            step();
            g++;
        end
        len = tick_cnt - t0;
    endtask

    initial begin
        logic [15:0] bits;
        int t0a, t0b, t0c, len, g, lows, t1;

        Rst_n    = 1'b0;
        tick_en  = 1'b0;
        tick_man = 1'b0;
        WrEn_a   = 1'b0;
        WrEn_p   = 1'b0;
        WrData   = '0;
        sel      = 1'b0;
        repeat (3) step();
        check_eq("rst_tx", 32'(tx_a), 1);
        check_eq("rst_busy", 32'(busy_a), 0);
        check_eq("rst_done", 32'(done_a), 0);
        check_eq("rst_ovf", 32'(ovf_a), 0);
        check_eq("rst_full", 32'(full_a), 0);
        check_eq("rst_empty", 32'(empty_a), 1);
        check_eq("rst_tx_p", 32'(tx_p), 1);
        @(negedge Clk);
        Rst_n   = 1'b1;
        tick_en = 1'b1;

        // Single 0x55 frame, 8N1.
        wr(1'b0, 8'h55);
        check_eq("single_empty", 32'(empty_a), 0);
        rx_frame(10, bits, t0a, len);
        check_eq("single_frame", 32'(bits[9:0]), 32'h2AA);
        check_eq("single_len", len, 160);
        check_eq("single_busy", 32'(busy_a), 0);
        step();
        check_eq("single_done_pulse", 32'(done_a), 0);

        // Even parity over 0x07 -> parity bit 1, 176 ticks.
        sel = 1'b1;
        wr(1'b1, 8'h07);
        rx_frame(11, bits, t0a, len);
        check_eq("par_frame", 32'(bits[10:0]), 32'h60E);
        check_eq("par_len", len, 176);
        check_eq("par_busy", 32'(busy_p), 0);
        sel = 1'b0;

        // Back-to-back frames with no gap.
        wr(1'b0, 8'hA5);
        wr(1'b0, 8'h3C);
        wr(1'b0, 8'hFF);
        rx_frame(10, bits, t0a, len);
        check_eq("b2b_frame0", 32'(bits[9:0]), 32'(frame8(8'hA5)));
        rx_frame(10, bits, t0b, len);
        check_eq("b2b_frame1", 32'(bits[9:0]), 32'(frame8(8'h3C)));
        check_eq("b2b_gap01", t0b - t0a, 160);
        check_eq("b2b_empty", 32'(empty_a), 1);
        rx_frame(10, bits, t0c, len);
        check_eq("b2b_frame2", 32'(bits[9:0]), 32'(frame8(8'hFF)));
        check_eq("b2b_total", t0c - t0a + len, 480);
        check_eq("b2b_busy", 32'(busy_a), 0);

        // Overflow: 17 writes with Tick stopped.
        tick_en = 1'b0;
        repeat (4) step();
        for (int i = 0; i < 16; i++) wr(1'b0, 8'h30 + 8'(i));
        check_eq("ovf_full", 32'(full_a), 1);
        wr(1'b0, 8'hEE);
        check_eq("ovf_pulse", 32'(ovf_a), 1);
        step();
        check_eq("ovf_pulse_end", 32'(ovf_a), 0);
        check_eq("ovf_idle_tx", 32'(tx_a), 1);
        tick_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rx_frame(10, bits, t0a, len);
            check_eq($sformatf("ovf_frame%0d", i), 32'(bits[9:0]),
                     32'(frame8(8'h30 + 8'(i))));
        end
        check_eq("ovf_drained_busy", 32'(busy_a), 0);
        check_eq("ovf_drained_empty", 32'(empty_a), 1);
        t1 = tick_cnt;
        lows = 0;
        g = 0;
        while (tick_cnt < t1 + 40 && g < 400) begin
            step();
            if (tx_a !== 1'b1) lows++;
            g++;
        end
        check_eq("ovf_no_17th", lows, 0);

        // Full + pop collision: write dropped, count ends at 15.
        tick_en = 1'b0;
        repeat (4) step();
        for (int i = 0; i < 16; i++) wr(1'b0, 8'h40 + 8'(i));
        check_eq("col_full", 32'(full_a), 1);
        @(negedge Clk);
        tick_man = 1'b1;
        WrEn_a   = 1'b1;
        WrData   = 8'hEE;
        @(posedge Clk);
        #1;
        tick_man = 1'b0;
        WrEn_a   = 1'b0;
        check_eq("col_ovf", 32'(ovf_a), 1);
        check_eq("col_full_after", 32'(full_a), 0);
        check_eq("col_tx_start", 32'(tx_a), 0);
        wr(1'b0, 8'h77);
        check_eq("col_refill_full", 32'(full_a), 1);
        wr(1'b0, 8'h78);
        check_eq("col_refill_ovf", 32'(ovf_a), 1);

        // Reset mid-frame at tick 50.
        @(negedge Clk);
        Rst_n = 1'b0;
        @(negedge Clk);
        Rst_n   = 1'b1;
        tick_en = 1'b1;
        wr(1'b0, 8'h00);
        g = 0;
        while (tx_a !== 1'b0 && g < 400) begin
            step();
            g++;
        end
        t0a = tick_cnt;
        g = 0;
        while (tick_cnt < t0a + 50 && g < 400) begin
            step();
            g++;
        end
        check_eq("mid_tx_low", 32'(tx_a), 0);
        #2;
        Rst_n = 1'b0;
        #1;
        check_eq("mid_rst_tx", 32'(tx_a), 1);
        check_eq("mid_rst_busy", 32'(busy_a), 0);
        check_eq("mid_rst_done", 32'(done_a), 0);
        check_eq("mid_rst_ovf", 32'(ovf_a), 0);
        check_eq("mid_rst_full", 32'(full_a), 0);
        check_eq("mid_rst_empty", 32'(empty_a), 1);
        @(negedge Clk);
        Rst_n = 1'b1;
        t1 = tick_cnt;
        lows = 0;
        g = 0;
        while (tick_cnt < t1 + 100 && g < 1000) begin
            step();
            if (tx_a !== 1'b1 || busy_a !== 1'b0) lows++;
            g++;
        end
        check_eq("post_rst_silent", lows, 0);
        check_eq("post_rst_empty", 32'(empty_a), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Buffered RS-232 transmitter: a host-side byte FIFO feeding an 8N1 serializer (optional even parity) clocked by the shared 16x-oversampling baud `Tick` from `UART_BaudRate_generator`. It is the transmit-direction counterpart of the receive path. A host or command engine writes bytes at system-clock rate, and the block drains them onto `Tx` back-to-back, with no idle gap between queued frames.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, 2..64.
- `NBITS`, 8: data bits per frame, 5..8.
- `PARITY_EN`, 0: 1 inserts an even-parity bit after the data bits.
- `Clk` input 1: system clock; all logic on rising edge.
- `Rst_n` input 1: one clock; reset is asynchronous and active-low.
- `Tick` input 1: one-`Clk` pulse at 16x baud rate.
- `WrEn` input 1: write strobe; accepted only when `Full`=0.
- `WrData` input 8: byte to queue; bits above `NBITS`-1 ignored.
- `Full` output 1: FIFO holds `DEPTH` entries.
- `Empty` output 1: FIFO holds 0 entries.
- `Overflow` output 1: one-cycle pulse when `WrEn`=1 while `Full`=1; byte dropped.
- `Tx` output 1: serial line, idles high.
- `TxBusy` output 1: high from start-bit entry until the stop bit completes with nothing queued.
- `TxDone` output 1: one-cycle pulse on the `Clk` that completes each stop bit.

## Operation
- FIFO:
  - Circular buffer with read/write pointers, each `$clog2(DEPTH)` bits, wrapping modulo `DEPTH`.
  - Occupancy count is `$clog2(DEPTH)+1` bits.
  - `Full` and `Empty` decode from the registered count.
  - A write on a cycle where `Full`=1 is dropped, even if a pop occurs on the same cycle.
  - A simultaneous accepted write and pop leaves the count unchanged.
- Serializer FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START: on `Tick` with `Empty`=0. Pop the head into the shift register, drive `Tx`=0, clear the tick counter.
  - Bit period: each bit holds for exactly 16 `Tick`s; a 4-bit tick counter wraps 15->0 at each bit boundary.
  - START -> DATA: after 16 ticks. Data goes out LSB first; a bit counter runs 0..`NBITS`-1.
  - DATA -> PARITY: when `PARITY_EN`=1. Parity bit = XOR of the `NBITS` data bits.
  - DATA -> STOP: when `PARITY_EN`=0.
  - STOP: `Tx`=1 for 16 ticks. On the 16th tick, pulse `TxDone`.
    - If the FIFO is non-empty, pop and go directly to START on that same `Clk`, so the next start bit begins immediately.
    - Otherwise go to IDLE and drop `TxBusy`.
- `Tx` and `TxBusy` are registered outputs, never combinational from the FSM.

## Timing
- Reset values: `Tx`=1, `TxBusy`=0, `TxDone`=0, `Overflow`=0, `Full`=0, `Empty`=1; FSM in IDLE; pointers and count at 0.
- Write-to-flag latency: `Empty` falls, or `Full` rises, on the `Clk` after the accepted `WrEn`.
- Start latency: from `Empty`=0 to `Tx` falling is at most one `Tick` period plus one `Clk`.
- Frame length: (1 + `NBITS` + `PARITY_EN` + 1) x 16 ticks, i.e. 160 ticks for 8N1 and 176 with parity.
- All `Tx` transitions occur exactly one `Clk` after the qualifying `Tick`.
- Asserting `Rst_n` mid-frame:
  - `Tx` returns high asynchronously.
  - The FIFO empties and the partial frame is lost.
  - After release, nothing is transmitted until a new write.
- `Tick` is ignored while in IDLE with `Empty`=1; no drift accumulates.

## Structure
- Shared `uart_pkg` holds:
  - the state typedef (IDLE, START, DATA, PARITY, STOP);
  - the constant `OVERSAMPLE`=16;
  - the constant `TICK_CW`=4.
- One sub-module, `uart_tx_fifo`, with parameter `DEPTH`:
  - ports `Clk`, `Rst_n`, `WrEn`, `WrData`, `RdEn`, `RdData`, `Full`, `Empty`;
  - `RdData` shows the head combinationally;
  - the top holds the FSM and counters.

## Test plan
- Single byte: write 0x55 with `PARITY_EN`=0.
  - `Tx` = 0,1,0,1,0,1,0,1,0,1 (start, data LSB first, stop), 16 ticks per bit.
  - One `TxDone` pulse at tick 160; `TxBusy` drops on the same cycle.
- Parity: write 0x07 with `PARITY_EN`=1.
  - Parity bit = 1.
  - Frame = 176 ticks.
- Back-to-back: write 0xA5, 0x3C, 0xFF in consecutive cycles.
  - Three contiguous frames, 480 ticks total.
  - No high gap beyond the 16-tick stop bit; `Empty`=1 after the third pop.
- Overflow (`DEPTH`=16): write 17 bytes with no `Tick`.
  - `Full`=1 after the 16th write.
  - 17th write pulses `Overflow` and is never transmitted.
  - Once `Tick` starts, exactly 16 bytes are sent in order.
- Full + pop collision: with `Full`=1, write on the same `Clk` as a pop.
  - Write is dropped and `Overflow` pulses.
  - Count goes to 15.
- Reset mid-frame: assert `Rst_n`=0 at tick 50 of a frame.
  - `Tx`=1 immediately; all flags at reset values.
  - No output after release until a new write.
